debug_capture: RTL and testbench

Parametrised successor of the 4-switch debugger. It debounces WIDTH asynchronous debug inputs and detects masked, edge-qualified changes. Each change is pushed as a timestamped event into an internal FIFO. A valid/ready stream feeds the Ethernet frame builder, so bursts of changes are buffered rather than lost.

---
 rtl/debug_pkg.sv | 31 +++
 rtl/debug_capture_debounce.sv | 42 ++++
 rtl/debug_capture.sv | 127 ++++++++++++
 tb/tb_debug_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug capture block.
// Holds edge-select encodings, event field offsets and a width helper.
package debug_pkg;

  // edge_sel encodings; 2'b11 behaves like EDGE_BOTH
  localparam logic [1:0] EDGE_BOTH = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;

  // Event word layout: {timestamp, state}; state sits at bit 0
  localparam int unsigned STATE_LSB = 0;

  // Timestamp field starts right above the WIDTH-bit state field
  function automatic int unsigned ts_lsb(input int unsigned width);
    return width;
  endfunction

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debug_capture_debounce.sv
// One debug channel: 2-FF synchroniser followed by a stability counter.
// Ports: clk, reset (async, active-high), w (raw input), db (debounced state).
module debounce_cnt
  import debug_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic db
);

  localparam int unsigned CW = clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic s1;
  logic s2;
  logic [CW-1:0] cnt;

  // Counter only runs while the synced input disagrees with the held state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= w;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_capture.sv
// Debounces WIDTH debug inputs, detects masked edge-qualified changes and
// queues {timestamp, state} events in a first-word-fall-through FIFO.
// Ports: clk, reset (async, active-high), w (raw inputs), mask, edge_sel,
// clr_ovf, data (debounced state), trigger (change pulse), out_valid /
// out_ready / out_data (event stream), fill (occupancy), overflow (sticky drop).
module debug_capture
  import debug_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          w,
  input  logic [WIDTH-1:0]          mask,
  input  logic [1:0]                edge_sel,
  input  logic                      clr_ovf,
  output logic [WIDTH-1:0]          data,
  output logic                      trigger,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_WIDTH+WIDTH-1:0] out_data,
  output logic [clog2(DEPTH):0]     fill,
  output logic                      overflow
);

  localparam int unsigned AW  = clog2(DEPTH);
  localparam int unsigned EW  = TS_WIDTH + WIDTH;
  localparam int unsigned TSL = ts_lsb(WIDTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0]    db;
  logic [TS_WIDTH-1:0] ts;
  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;
  logic [WIDTH-1:0] qual_c;
  logic             push_c;
  logic             pop_c;
  logic             accept_c;
  logic             drop_c;
  logic [AW:0]      fill_next_c;
  logic [EW-1:0]    event_c;

  // Per-channel synchroniser and debounce
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_cnt #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .w     (w[i]),
      .db    (db[i])
    );
  end

  // Change qualification and FIFO control
  always_comb begin
    rise_c      = db & ~data;
    fall_c      = ~db & data;
    qual_c      = '0;
    event_c     = '0;
    fill_next_c = fill;
    case (edge_sel)
      EDGE_RISE: qual_c = rise_c & mask;
      EDGE_FALL: qual_c = fall_c & mask;
      default:   qual_c = (rise_c | fall_c) & mask;
    endcase
    push_c   = |qual_c;
    pop_c    = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves on the same edge
    accept_c = push_c & ((fill < FULL) | pop_c);
    drop_c   = push_c & ~accept_c;
    if (accept_c && !pop_c) begin
      fill_next_c = fill + (AW + 1)'(1);
    end else if (pop_c && !accept_c) begin
      fill_next_c = fill - (AW + 1)'(1);
    end
    event_c[TSL +: TS_WIDTH]    = ts;
    event_c[STATE_LSB +: WIDTH] = db;
  end

  // State, timestamp, pointers and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      trigger   <= 1'b0;
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      data      <= db;
      trigger   <= push_c;
      ts        <= ts + TS_WIDTH'(1);
      fill      <= fill_next_c;
      out_valid <= (fill_next_c != '0);
      if (accept_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A new drop outranks a simultaneous clear
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Event storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= event_c;
    end
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_debug_capture.sv
// Self-checking bench for debug_capture (WIDTH=4, DB_CYCLES=4, DEPTH=4, TS_WIDTH=8).
module tb_debug_capture;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DBC   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TSW   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] mask;
  logic [1:0]       edge_sel;
  logic             clr_ovf;
  logic [WIDTH-1:0] data;
  logic             trigger;
  logic             out_valid;
  logic             out_ready;
  logic [TSW+WIDTH-1:0] out_data;
  logic [2:0]       fill;
  logic             overflow;

  always #5 clk = ~clk;

  debug_capture #(
    .WIDTH(WIDTH), .DB_CYCLES(DBC), .DEPTH(DEPTH), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk), .reset(reset), .w(w), .mask(mask), .edge_sel(edge_sel),
    .clr_ovf(clr_ovf), .data(data), .trigger(trigger), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fill(fill), .overflow(overflow)
  );

  int total = 0;
  int bad = 0;
  int trig_cnt = 0;
  int trig_base = 0;
  bit exp_qual;
  logic [WIDTH-1:0] exp_db;
  logic [TSW-1:0] tb_ts;
  logic [TSW+WIDTH-1:0] sb [$];
  logic [TSW+WIDTH-1:0] exp_ev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference timestamp: counts clocks since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 8'd1;
  end

  // Monitor: count trigger pulses and score popped events
  always @(negedge clk) begin
    if (!reset) begin
      if (trigger) trig_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_pop_empty", 32'(sb.size()), 32'd1);
        end else begin
          exp_ev = sb.pop_front();
          chk("event", 32'(out_data), 32'(exp_ev));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive a new input vector; event detect lands 6 clocks after this point
  task automatic apply(input logic [WIDTH-1:0] nw, input bit kept);
    logic [WIDTH-1:0] r, f, q;
    r = nw & ~exp_db;
    f = ~nw & exp_db;
    case (edge_sel)
      2'b01:   q = r;
      2'b10:   q = f;
      default: q = r | f;
    endcase
    q = q & mask;
    exp_qual = (q != '0);
    if (exp_qual && kept) sb.push_back({8'(tb_ts + 8'd6), nw});
    trig_base = trig_cnt;
    w = nw;
    exp_db = nw;
  endtask

  task automatic change(input logic [WIDTH-1:0] nw, input bit kept, input string tag);
    apply(nw, kept);
    repeat (9) tick;
    chk({tag, "_data"}, 32'(data), 32'(exp_db));
    chk({tag, "_trig"}, 32'(trig_cnt - trig_base), 32'(exp_qual));
  endtask

  initial begin
    int guard;
    int base2;
    reset = 1'b1; w = '0; mask = 4'hF; edge_sel = 2'b00;
    clr_ovf = 1'b0; out_ready = 1'b0; exp_db = '0;
    repeat (3) tick;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_trig", 32'(trigger), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    trig_base = trig_cnt;
    repeat (20) tick;
    chk("idle_trig", 32'(trig_cnt - trig_base), 32'd0);

    // 3-clock glitch must not propagate
    trig_base = trig_cnt;
    w = 4'b0001;
    repeat (3) tick;
    w = 4'b0000;
    repeat (10) tick;
    chk("glitch_data", 32'(data), 32'd0);
    chk("glitch_trig", 32'(trig_cnt - trig_base), 32'd0);

    // Held edge: data flips exactly 2+4+1 clocks later
    apply(4'b0001, 1'b1);
    repeat (6) tick;
    chk("db_early", 32'(data), 32'd0);
    tick;
    chk("db_data", 32'(data), 32'b0001);
    chk("db_trig_hi", 32'(trigger), 32'd1);
    chk("db_fill", 32'(fill), 32'd1);
    tick;
    chk("db_trig_lo", 32'(trigger), 32'd0);
    out_ready = 1'b1;
    repeat (3) tick;
    chk("db_drained", 32'(out_valid), 32'd0);
    chk("db_sb", 32'(sb.size()), 32'd0);

    // Edge select and mask
    change(4'b0011, 1'b1, "e_rise1");
    edge_sel = 2'b01;
    change(4'b0001, 1'b1, "e_fall_rmode");
    edge_sel = 2'b00;
    mask = 4'b1101;
    change(4'b0011, 1'b1, "m_rise1");
    change(4'b0001, 1'b1, "m_fall1");
    change(4'b0101, 1'b1, "m_rise2");
    chk("em_sb", 32'(sb.size()), 32'd0);

    // Overflow: five events with no drain, fifth is dropped
    mask = 4'hF;
    out_ready = 1'b0;
    change(4'b0100, 1'b1, "of1");
    change(4'b0000, 1'b1, "of2");
    change(4'b0001, 1'b1, "of3");
    change(4'b0011, 1'b1, "of4");
    chk("of_pre", 32'(overflow), 32'd0);
    change(4'b0111, 1'b0, "of5");
    chk("of_fill", 32'(fill), 32'd4);
    chk("of_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    chk("of_clr", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the detect edge
    apply(4'b1111, 1'b1);
    repeat (6) tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("fp_fill", 32'(fill), 32'd4);
    chk("fp_ovf", 32'(overflow), 32'd0);
    repeat (2) tick;
    chk("fp_trig", 32'(trig_cnt - trig_base), 32'd1);
    out_ready = 1'b1;
    repeat (6) tick;
    chk("fp_valid", 32'(out_valid), 32'd0);
    chk("fp_sb", 32'(sb.size()), 32'd0);

    // Timestamp wrap: detects at 0xFE and 0x02
    guard = 0;
    while (tb_ts != 8'hF8 && guard < 600) begin
      tick;
      guard++;
    end
    chk("ts_wait", 32'(tb_ts), 32'hF8);
    base2 = trig_cnt;
    apply(4'b1110, 1'b1);
    repeat (4) tick;
    apply(4'b1100, 1'b1);
    repeat (12) tick;
    chk("ts_data", 32'(data), 32'b1100);
    chk("ts_trig", 32'(trig_cnt - base2), 32'd2);
    chk("ts_valid", 32'(out_valid), 32'd0);
    chk("ts_fill", 32'(fill), 32'd0);
    chk("ts_sb", 32'(sb.size()), 32'd0);

    // Async reset mid-stream and mid-debounce
    out_ready = 1'b0;
    change(4'b1101, 1'b1, "mr_ev");
    chk("mr_fill", 32'(fill), 32'd1);
    apply(4'b1001, 1'b0);
    repeat (3) tick;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mr_data", 32'(data), 32'd0);
    chk("mr_trig", 32'(trigger), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_fill0", 32'(fill), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    sb.delete();
    w = '0;
    exp_db = '0;
    repeat (2) tick;
    reset = 1'b0;
    trig_base = trig_cnt;
    repeat (20) tick;
    chk("mr_idle_trig", 32'(trig_cnt - trig_base), 32'd0);
    chk("mr_idle_data", 32'(data), 32'd0);
    chk("mr_idle_fill", 32'(fill), 32'd0);

    chk("end_sb", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
